// File: rtl/dffs_multi_port_lane.sv
// dffs_multi_port_lane
//   Flop-based register array with NR registered read ports, NW lane-masked
//   write ports, a full-width bulk-update port and a hardware clear sequencer.
//   Contents are exported flattened on DFF for direct combinational use.
//
//   Optional feature macro: DFFS_BYPASS_EN
//     defined   : reads see same-edge writes per lane (and 0 for the entry
//                 being cleared).
//     undefined : reads always return pre-edge contents.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | normal operation, CLR sampled
//   CLEAR  | one entry zeroed per cycle, port and bulk writes dropped
module dffs_multi_port_lane #(
    parameter int SIZE  = 4,
    parameter int WLEN  = 32,
    parameter int LANES = 4,
    parameter int NR    = 2,
    parameter int NW    = 2
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          CEN,
    input  logic [NR*SIZE-1:0]            AR,
    output logic [NR*WLEN-1:0]            QR,
    input  logic [NW*SIZE-1:0]            AW,
    input  logic [NW*LANES-1:0]           WEN,
    input  logic [NW*WLEN-1:0]            DW,
    input  logic [(2**SIZE)-1:0]          WENB,
    input  logic [WLEN*(2**SIZE)-1:0]     DB,
    input  logic                          CLR,
    output logic                          BUSY,
    output logic [WLEN*(2**SIZE)-1:0]     DFF
);

    localparam int DEPTH = 2**SIZE;
    localparam int LW    = WLEN / LANES;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_q;
    logic [SIZE-1:0]       cnt_q;
    logic                  busy_q;
    logic [WLEN-1:0]       mem_q [DEPTH];
    logic [WLEN-1:0]       mem_d [DEPTH];
    logic [NR*WLEN-1:0]    qr_q;
    logic [NR*WLEN-1:0]    qr_d;

    // Next array contents: clear beats bulk, bulk beats ports, higher port beats lower.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (state_q == ST_CLEAR) begin
            mem_d[cnt_q] = '0;
        end else begin
            if (!CEN) begin
                for (int w = 0; w < NW; w++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (!WEN[w*LANES+l]) begin
                            mem_d[AW[w*SIZE+:SIZE]][l*LW+:LW] = DW[w*WLEN+l*LW+:LW];
                        end
                    end
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (!WENB[i]) begin
                    mem_d[i] = DB[i*WLEN+:WLEN];
                end
            end
        end
    end

    // Read data selection; the bypass build reads the post-edge view of the array.
    always_comb begin
        qr_d = qr_q;
        if (!CEN) begin
            for (int r = 0; r < NR; r++) begin
`ifdef DFFS_BYPASS_EN
                qr_d[r*WLEN+:WLEN] = mem_d[AR[r*SIZE+:SIZE]];
`else
                qr_d[r*WLEN+:WLEN] = mem_q[AR[r*SIZE+:SIZE]];
`endif
            end
        end
    end

    // Array storage.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Registered read ports.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            qr_q <= '0;
        end else begin
            qr_q <= qr_d;
        end
    end

    // Clear sequencer: BUSY is registered, so it rises the cycle after CLR and
    // falls on the edge that zeroes the last entry.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CLR) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == {SIZE{1'b1}}) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + SIZE'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Flattened export of the array.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dff
        assign DFF[gi*WLEN+:WLEN] = mem_q[gi];
    end

    assign QR   = qr_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_dffs_multi_port_lane.sv
// Testbench for dffs_multi_port_lane: random and directed stimulus against a
// behavioural array model; read responses go through a scoreboard queue and
// are checked by an independent monitor.
module tb_dffs_multi_port_lane;

    localparam int SIZE  = 4;
    localparam int WLEN  = 32;
    localparam int LANES = 4;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 16;
    localparam int LW    = 8;

`ifdef DFFS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                      CLK = 1'b0;
    logic                      RSTN;
    logic                      cen;
    logic [NR*SIZE-1:0]        ar;
    logic [NR*WLEN-1:0]        QR;
    logic [NW*SIZE-1:0]        aw;
    logic [NW*LANES-1:0]       wen;
    logic [NW*WLEN-1:0]        dw;
    logic [DEPTH-1:0]          wenb;
    logic [WLEN*DEPTH-1:0]     db;
    logic                      clr;
    logic                      BUSY;
    logic [WLEN*DEPTH-1:0]     DFF;

    dffs_multi_port_lane #(
        .SIZE(SIZE), .WLEN(WLEN), .LANES(LANES), .NR(NR), .NW(NW)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .CEN(cen), .AR(ar), .QR(QR),
        .AW(aw), .WEN(wen), .DW(dw), .WENB(wenb), .DB(db),
        .CLR(clr), .BUSY(BUSY), .DFF(DFF)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int                 tag;
        logic [NR*WLEN-1:0] qr;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [WLEN-1:0] m_mem [DEPTH];
    logic [WLEN-1:0] m_qr  [NR];
    int              clr_left;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected read data due after each active edge.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].tag < cyc) begin
            errors++;
            $display("FAIL qr_missed tag=%0d now=%0d", sb[0].tag, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].tag == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("qr", {448'd0, QR}, {448'd0, e.qr});
        end
    end

    function automatic logic [WLEN*DEPTH-1:0] flat_model();
        logic [WLEN*DEPTH-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*WLEN+:WLEN] = m_mem[i];
        return f;
    endfunction

    task automatic idle_in();
        cen  = 1'b1;
        wen  = '1;
        wenb = '1;
        clr  = 1'b0;
    endtask

    // Apply the current inputs for one clock, advancing the model alongside.
    task automatic step();
        logic [WLEN-1:0] nm [DEPTH];
        logic [WLEN-1:0] mask;
        logic [NR*WLEN-1:0] eqr;
        int a;
        exp_t e;
        for (int i = 0; i < DEPTH; i++) nm[i] = m_mem[i];
        if (clr_left > 0) begin
            nm[DEPTH - clr_left] = '0;
        end else begin
            if (!cen) begin
                for (int w = 0; w < NW; w++)
                    for (int l = 0; l < LANES; l++)
                        if (!wen[w*LANES+l]) begin
                            mask = ((32'h1 << LW) - 32'h1) << (l*LW);
                            a = int'(aw[w*SIZE+:SIZE]);
                            nm[a] = (nm[a] & ~mask) | (dw[w*WLEN+:WLEN] & mask);
                        end
            end
            for (int i = 0; i < DEPTH; i++)
                if (!wenb[i]) nm[i] = db[i*WLEN+:WLEN];
        end
        if (!cen) begin
            for (int r = 0; r < NR; r++) begin
                a = int'(ar[r*SIZE+:SIZE]);
                m_qr[r] = BYP ? nm[a] : m_mem[a];
            end
        end
        for (int r = 0; r < NR; r++) eqr[r*WLEN+:WLEN] = m_qr[r];
        e.tag = cyc + 1;
        e.qr  = eqr;
        sb.push_back(e);
        if (clr_left > 0) clr_left--;
        else if (clr) clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = nm[i];
        @(posedge CLK);
        #1;
        chk("busy", {511'd0, BUSY}, {511'd0, (clr_left > 0)});
        chk("dff", DFF, flat_model());
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int r = 0; r < NR; r++) m_qr[r] = '0;
        clr_left = 0;
        sb.delete();
    endtask

    task automatic wr1(input int port, input int addr, input logic [3:0] lanes_n,
                       input logic [31:0] data);
        aw[port*SIZE+:SIZE]   = SIZE'(addr);
        wen[port*LANES+:LANES] = lanes_n;
        dw[port*WLEN+:WLEN]   = data;
    endtask

    initial begin
        int n;
        RSTN = 1'b0;
        ar = '0; aw = '0; dw = '0; db = '0;
        idle_in();
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", {511'd0, BUSY}, 512'd0);
        chk("rst_dff", DFF, '0);
        chk("rst_qr", {448'd0, QR}, 512'd0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Read every entry after reset
        for (int i = 0; i < DEPTH; i += 2) begin
            idle_in();
            cen = 1'b0;
            ar  = {4'(i + 1), 4'(i)};
            step();
        end

        // Same-edge read and write of entry 7
        idle_in();
        cen = 1'b0;
        ar  = {4'd0, 4'd7};
        wr1(0, 7, 4'b0000, 32'hFFFF0000);
        step();
        chk("byp_qr", {480'd0, QR[31:0]}, {480'd0, (BYP ? 32'hFFFF0000 : 32'h0)});
        idle_in();
        cen = 1'b0;
        ar  = {4'd0, 4'd7};
        step();
        chk("byp_qr_next", {480'd0, QR[31:0]}, {480'd0, 32'hFFFF0000});

        // Lane-masked write over existing data
        idle_in();
        cen = 1'b0;
        wr1(0, 3, 4'b0000, 32'h11223344);
        step();
        idle_in();
        cen = 1'b0;
        wr1(0, 3, 4'b1010, 32'hAABBCCDD);
        step();
        chk("lane_mask", {480'd0, DFF[3*WLEN+:WLEN]}, {480'd0, 32'h11BB33DD});
        idle_in();
        cen = 1'b0;
        ar  = {4'd3, 4'd3};
        step();

        // Two ports plus bulk to entry 5, then ports only
        idle_in();
        cen = 1'b0;
        wr1(0, 5, 4'b0000, 32'h1);
        wr1(1, 5, 4'b0000, 32'h2);
        wenb[5] = 1'b0;
        db[5*WLEN+:WLEN] = 32'h9;
        step();
        chk("bulk_wins", {480'd0, DFF[5*WLEN+:WLEN]}, {480'd0, 32'h9});
        idle_in();
        cen = 1'b0;
        wr1(0, 5, 4'b0000, 32'h1);
        wr1(1, 5, 4'b0000, 32'h2);
        step();
        chk("port1_wins", {480'd0, DFF[5*WLEN+:WLEN]}, {480'd0, 32'h2});

        // Bulk with CEN high still writes
        idle_in();
        wenb = '0;
        for (int i = 0; i < DEPTH; i++) db[i*WLEN+:WLEN] = $urandom | 32'h1;
        step();

        // Full clear with a mid-clear write, bulk and repeated CLR
        idle_in();
        clr = 1'b1;
        step();
        n = 0;
        while (BUSY && n < 40) begin
            idle_in();
            cen = 1'b0;
            ar  = {4'(n), 4'(n + 1)};
            if (n == 3) wr1(0, 15, 4'b0000, 32'hDEADBEEF);
            if (n == 6) begin
                clr  = 1'b1;
                wenb = 16'h7FFF;
                db[15*WLEN+:WLEN] = 32'hCAFEF00D;
            end
            step();
            n++;
        end
        chk("busy_len", 512'(n), 512'd16);
        chk("clear_dff", DFF, '0);
        idle_in();
        step();
        chk("no_restart", {511'd0, BUSY}, 512'd0);

        // Reset in the middle of a clear
        idle_in();
        wenb = '0;
        for (int i = 0; i < DEPTH; i++) db[i*WLEN+:WLEN] = $urandom | 32'h1;
        step();
        idle_in();
        clr = 1'b1;
        step();
        repeat (5) begin
            idle_in();
            step();
        end
        @(negedge CLK);
        #1;
        RSTN = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_busy", {511'd0, BUSY}, 512'd0);
        chk("rst_mid_dff", DFF, '0);
        @(negedge CLK);
        RSTN = 1'b1;
        idle_in();
        cen = 1'b0;
        wr1(1, 9, 4'b0000, 32'h5A5A5A5A);
        step();
        chk("post_rst_wr", {480'd0, DFF[9*WLEN+:WLEN]}, {480'd0, 32'h5A5A5A5A});

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            cen = ($urandom_range(0, 3) == 0);
            ar  = NR*SIZE'($urandom);
            aw  = NW*SIZE'($urandom);
            if ($urandom_range(0, 3) == 0) aw[SIZE+:SIZE] = aw[0+:SIZE];
            wen = NW*LANES'($urandom);
            dw  = {$urandom, $urandom};
            for (int i = 0; i < DEPTH; i++) begin
                wenb[i] = ($urandom_range(0, 15) != 0);
                db[i*WLEN+:WLEN] = $urandom;
            end
            clr = ($urandom_range(0, 60) == 0);
            step();
        end

        idle_in();
        step();
        @(negedge CLK);
        #1;
        chk("sb_drained", 512'(sb.size()), 512'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
